conv_window_tracker: RTL

- Parametrised successor to the fixed 100-wide, 3x3/stride-2 row counter in the conv unit.
- Tracks the column and row of every accepted pixel in a raster-order image stream.
- Flags exactly the pixels that complete a KxK convolution window at the configured stride, and reports frame completion.
- Sits beside the line buffers and gates the MAC array's result write.

---
 rtl/conv_window_tracker.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_window_tracker.sv
// conv_window_tracker
//   Follows a raster-order pixel stream and tracks the column and row of every
//   accepted pixel. Flags each pixel that completes a KxK window at the
//   configured stride, counts those windows, and pulses at the end of a frame.
//   Sits beside the line buffers and gates the MAC array's result write.
//
//   Optional build macro CONV_WINDOW_TRACKER_IDX_EN adds Win_Col / Win_Row,
//   the output-map coordinate of each completed window.
//
// Ports
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous, active-low reset
//   En         in   one pixel accepted this cycle
//   Clr        in   synchronous restart to frame start (wins over En)
//   Row_Active out  current row index >= K-1
//   Win_Valid  out  pulse: the accepted pixel completed a strided window
//   Frame_Done out  one-cycle pulse after the last pixel of the frame
//   Busy       out  frame in progress
//   Win_Count  out  windows emitted in the current frame (saturating)
//   Win_Col    out  output-map column of the last window (IDX_EN only)
//   Win_Row    out  output-map row of the last window (IDX_EN only)
module conv_window_tracker #(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int K      = 3,
    parameter int STRIDE = 2,
    parameter int CNT_W  = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Clr,
    output logic             Row_Active,
    output logic             Win_Valid,
    output logic             Frame_Done,
    output logic             Busy,
`ifdef CONV_WINDOW_TRACKER_IDX_EN
    output logic [CNT_W-1:0] Win_Col,
    output logic [CNT_W-1:0] Win_Row,
`endif
    output logic [CNT_W-1:0] Win_Count
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    col, col_nxt;
    logic [RW-1:0]    row, row_nxt;
    logic [PW-1:0]    col_ph, col_ph_nxt;
    logic [PW-1:0]    row_ph, row_ph_nxt;
    logic             col_last, row_last, frame_last;
    logic             win_p0;
    logic [CNT_W-1:0] cnt_base;

    // Phase counters replace a modulo: they step 0..STRIDE-1 and wrap.
    function automatic logic [PW-1:0] ph_adv(input logic [PW-1:0] p);
        return (p == PH_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: coordinate update and window decision for the accepted pixel
    always_comb begin
        col_last   = (col == COL_LAST);
        row_last   = (row == ROW_LAST);
        frame_last = col_last && row_last;

        col_nxt    = col_last ? '0 : col + 1'b1;
        row_nxt    = row;
        row_ph_nxt = row_ph;
        if (col_last) begin
            row_nxt    = row_last ? '0 : row + 1'b1;
            // Phases restart exactly where the first full window can land.
            row_ph_nxt = (row_nxt == ROW_K1) ? '0 : ph_adv(row_ph);
        end
        col_ph_nxt = (col_nxt == COL_K1) ? '0 : ph_adv(col_ph);

        win_p0 = En && (row >= ROW_K1) && (col >= COL_K1) &&
                 (row_ph == '0) && (col_ph == '0);

        // Count restarts the cycle after Frame_Done, even while a new
        // frame's first pixel is already being accepted.
        cnt_base = Frame_Done ? '0 : Win_Count;

        case (state)
            IDLE:    state_nxt = frame_last ? IDLE :
                                 (row_nxt >= ROW_K1) ? ACTIVE : FILL;
            FILL:    state_nxt = (row_nxt >= ROW_K1) ? ACTIVE : FILL;
            ACTIVE:  state_nxt = frame_last ? IDLE : ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered outputs, one cycle after the accepted pixel
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            col_ph     <= '0;
            row_ph     <= '0;
            Row_Active <= 1'b0;
            Win_Valid  <= 1'b0;
            Frame_Done <= 1'b0;
            Busy       <= 1'b0;
            Win_Count  <= '0;
        end else if (Clr) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            col_ph     <= '0;
            row_ph     <= '0;
            Row_Active <= 1'b0;
            Win_Valid  <= 1'b0;
            Frame_Done <= 1'b0;
            Busy       <= 1'b0;
            Win_Count  <= '0;
        end else begin
            Win_Valid  <= win_p0;
            Frame_Done <= En && frame_last;
            Win_Count  <= win_p0 ? sat_inc(cnt_base) : cnt_base;
            if (En) begin
                col        <= col_nxt;
                row        <= row_nxt;
                col_ph     <= col_ph_nxt;
                row_ph     <= row_ph_nxt;
                Row_Active <= (row_nxt >= ROW_K1);
                state      <= state_nxt;
                Busy       <= (state_nxt != IDLE);
            end
        end
    end

`ifdef CONV_WINDOW_TRACKER_IDX_EN
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam logic [CNT_W-1:0] OC_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] OR_LAST = CNT_W'(OUT_H - 1);

    logic [CNT_W-1:0] oc_cnt, or_cnt;

    // The final window of a frame is always (OUT_W-1, OUT_H-1), so the
    // natural wrap of these counters also restarts them per frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            oc_cnt  <= '0;
            or_cnt  <= '0;
            Win_Col <= '0;
            Win_Row <= '0;
        end else if (Clr) begin
            oc_cnt  <= '0;
            or_cnt  <= '0;
            Win_Col <= '0;
            Win_Row <= '0;
        end else if (win_p0) begin
            Win_Col <= oc_cnt;
            Win_Row <= or_cnt;
            if (oc_cnt == OC_LAST) begin
                oc_cnt <= '0;
                or_cnt <= (or_cnt == OR_LAST) ? '0 : or_cnt + 1'b1;
            end else begin
                oc_cnt <= oc_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
